// File: rtl/time_update_if.sv
// Control/status bundle between the time-update controller and the datapath.
// The controller drives the strobes and set values; the datapath returns time and status.
interface time_update_if;
  logic [1:0] s;
  logic       Kc;
  logic       La;
  logic       Ea;
  logic       Lr;
  logic       Er;
  logic       set_en;
  logic [5:0] set_sec;
  logic [5:0] set_min;
  logic [4:0] set_hr;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic       u;
  logic       day_tick;

  modport master (
    output s, Kc, La, Ea, Lr, Er, set_en, set_sec, set_min, set_hr,
    input  sec, min, hr, u, day_tick
  );

  modport slave (
    input  s, Kc, La, Ea, Lr, Er, set_en, set_sec, set_min, set_hr,
    output sec, min, hr, u, day_tick
  );
endinterface

// File: rtl/time_update_dp.sv
// Time-of-day datapath: field registers sec/min/hr plus a K-indexed A -> S -> field
// pipeline that adds 0/+1/-1 modulo the selected field's limit.
module time_update_dp (
  input  logic           clk,
  input  logic           rst_n,
  time_update_if.slave   bus
);

  logic [1:0] k_r;
  logic [5:0] a_r;
  logic [5:0] s_r;
  logic       c_r;
  logic       u_r;
  logic [5:0] sec_r;
  logic [5:0] min_r;
  logic [4:0] hr_r;
  logic       day_tick_r;

  logic [5:0] field_sel_s;
  logic [5:0] sum_s;
  logic       carry_s;

  function automatic logic [5:0] field_limit(input logic [1:0] k);
    case (k)
      2'd0:    return 6'd60;
      2'd1:    return 6'd60;
      2'd2:    return 6'd24;
      default: return 6'd60;
    endcase
  endfunction

  // Returns {wrap, sum} for a + operand(op) modulo lim.
  function automatic logic [6:0] wrap_add(input logic [5:0] a, input logic [1:0] op,
                                          input logic [5:0] lim);
    case (op)
      2'b01: begin
        if (a == lim - 6'd1) return {1'b1, 6'd0};
        else                 return {1'b0, a + 6'd1};
      end
      2'b10: begin
        if (a == 6'd0) return {1'b1, lim - 6'd1};
        else           return {1'b0, a - 6'd1};
      end
      default: return {1'b0, a};
    endcase
  endfunction

  // Field selected by K for loading into A.
  always_comb begin
    field_sel_s = 6'd0;
    case (k_r)
      2'd0:    field_sel_s = sec_r;
      2'd1:    field_sel_s = min_r;
      2'd2:    field_sel_s = {1'b0, hr_r};
      default: field_sel_s = 6'd0;
    endcase
  end

  // Modular adder on A using the limit of the current field.
  always_comb begin
    {carry_s, sum_s} = wrap_add(a_r, bus.s, field_limit(k_r));
  end

  // All datapath state; set_en takes priority and freezes the update pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_r        <= 2'd0;
      a_r        <= 6'd0;
      s_r        <= 6'd0;
      c_r        <= 1'b0;
      u_r        <= 1'b0;
      sec_r      <= 6'd0;
      min_r      <= 6'd0;
      hr_r       <= 5'd0;
      day_tick_r <= 1'b0;
    end else if (bus.set_en) begin
      sec_r      <= (bus.set_sec >= 6'd60) ? 6'd0 : bus.set_sec;
      min_r      <= (bus.set_min >= 6'd60) ? 6'd0 : bus.set_min;
      hr_r       <= (bus.set_hr  >= 5'd24) ? 5'd0 : bus.set_hr;
      day_tick_r <= 1'b0;
    end else begin
      if (bus.Kc) begin
        k_r <= 2'd0;
        u_r <= 1'b0;
      end else begin
        if (bus.Er && (k_r < 2'd2)) begin
          k_r <= k_r + 2'd1;
        end
        if (bus.Lr) begin
          u_r <= c_r;
        end
      end
      if (bus.La) begin
        a_r <= field_sel_s;
      end
      if (bus.Ea) begin
        s_r <= sum_s;
        c_r <= carry_s;
      end
      if (bus.Lr) begin
        case (k_r)
          2'd0:    sec_r <= s_r;
          2'd1:    min_r <= s_r;
          2'd2:    hr_r  <= s_r[4:0];
          default: sec_r <= sec_r;
        endcase
      end
      day_tick_r <= bus.Lr && (k_r == 2'd2) && c_r;
    end
  end

  assign bus.sec      = sec_r;
  assign bus.min      = min_r;
  assign bus.hr       = hr_r;
  assign bus.u        = u_r;
  assign bus.day_tick = day_tick_r;

endmodule

// File: tb/tb_time_update_dp.sv
// Directed bench for time_update_dp: expected time/status snapshots are queued
// as each step is driven and compared once the step's clock edge has passed.
module tb_time_update_dp;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  time_update_if bus ();

  time_update_dp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [18:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic idle_inputs();
    bus.s       = 2'b00;
    bus.Kc      = 1'b0;
    bus.La      = 1'b0;
    bus.Ea      = 1'b0;
    bus.Lr      = 1'b0;
    bus.Er      = 1'b0;
    bus.set_en  = 1'b0;
    bus.set_sec = 6'd0;
    bus.set_min = 6'd0;
    bus.set_hr  = 5'd0;
  endtask

  task automatic cyc(input logic kc, input logic la, input logic ea, input logic lr,
                     input logic er, input logic [1:0] sv);
    bus.Kc = kc;
    bus.La = la;
    bus.Ea = ea;
    bus.Lr = lr;
    bus.Er = er;
    bus.s  = sv;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                      input logic with_lr);
    bus.set_en  = 1'b1;
    bus.set_hr  = h;
    bus.set_min = m;
    bus.set_sec = s;
    bus.Lr      = with_lr;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic push(input string tag, input logic [4:0] h, input logic [5:0] m,
                      input logic [5:0] s, input logic uu, input logic dt);
    exp_t e;
    e.tag = tag;
    e.val = {h, m, s, uu, dt};
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t        e;
    logic [18:0] obs;
    obs = {bus.hr, bus.min, bus.sec, bus.u, bus.day_tick};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%h required=an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed hr=%0d min=%0d sec=%0d u=%0b tick=%0b required hr=%0d min=%0d sec=%0d u=%0b tick=%0b",
               e.tag, obs[18:14], obs[13:8], obs[7:2], obs[1], obs[0],
               e.val[18:14], e.val[13:8], e.val[7:2], e.val[1], e.val[0]);
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    // Reset state
    push("reset", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    sb_check();
    rst_n = 1'b1;

    // Single seconds increment from 00:00:05
    load(5'd0, 6'd0, 6'd5, 1'b0);
    push("set_000005", 5'd0, 6'd0, 6'd5, 1'b0, 1'b0);
    sb_check();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    push("sec_inc", 5'd0, 6'd0, 6'd6, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    sb_check();

    // Seconds wrap carries into minutes
    load(5'd0, 6'd0, 6'd59, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    push("sec_wrap", 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    sb_check();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    push("min_inc", 5'd0, 6'd1, 6'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    sb_check();

    // Full ripple 23:59:59 -> 00:00:00 with day tick
    load(5'd23, 6'd59, 6'd59, 1'b0);
    push("set_max_in_range", 5'd23, 6'd59, 6'd59, 1'b0, 1'b0);
    sb_check();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    push("ripple_sec", 5'd23, 6'd59, 6'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    sb_check();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    push("ripple_min", 5'd23, 6'd0, 6'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    sb_check();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    push("ripple_hr_tick", 5'd0, 6'd0, 6'd0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    sb_check();
    push("tick_single", 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    sb_check();

    // Out-of-range set values clamp to zero
    load(5'd24, 6'd60, 6'd59, 1'b0);
    push("set_limits", 5'd0, 6'd0, 6'd59, 1'b1, 1'b0);
    sb_check();

    // Overlapped La/Ea/Lr use pre-edge values
    load(5'd0, 6'd0, 6'd10, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
    push("pipeline", 5'd0, 6'd0, 6'd11, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
    sb_check();

    // Borrow on seconds from 00:00:00
    load(5'd0, 6'd0, 6'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
    push("sec_borrow", 5'd0, 6'd0, 6'd59, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    sb_check();
    push("ea_zero_op", 5'd0, 6'd0, 6'd59, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    sb_check();

    // set_en overrides a concurrent Lr (pending S=0, c=0 must not land)
    load(5'd25, 6'd61, 6'd30, 1'b1);
    push("set_over_lr", 5'd0, 6'd0, 6'd30, 1'b1, 1'b0);
    sb_check();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    push("k_kept_by_set", 5'd0, 6'd0, 6'd31, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    sb_check();

    // K saturates at 2 under repeated Er
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    load(5'd5, 6'd0, 6'd31, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    push("k_saturate", 5'd6, 6'd0, 6'd31, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    sb_check();

    // Reset between Ea and Lr abandons the update
    load(5'd12, 6'd34, 6'd56, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    rst_n  = 1'b0;
    bus.Lr = 1'b1;
    push("mid_update_reset", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    idle_inputs();
    sb_check();
    rst_n = 1'b1;
    push("post_reset_lr", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    sb_check();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    push("post_reset_update", 5'd0, 6'd0, 6'd1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    sb_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_update_dp.md
TIME_UPDATE_DP -- requirements
Module: time_update_dp

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 s  input  2  adder operand select: 00 -> 0, 01 -> +1, 10 -> -1, 11 -> 0.
REQ-004 Kc  input  1  clear field index K and carry flag u.
REQ-005 La  input  1  load operand register A from the field selected by K.
REQ-006 Ea  input  1  enable adder; capture wrapped sum into S and wrap flag into c.
REQ-007 Lr  input  1  write S back into the field selected by K; copy c to u.
REQ-008 Er  input  1  advance field index K.
REQ-009 set_en  input  1  external time load strobe.
REQ-010 set_sec, set_min  input  6 each  external load values, binary.
REQ-011 set_hr  input  5  external load value, binary.
REQ-012 sec, min  output  6 each  current seconds/minutes, binary.
REQ-013 hr  output  5  current hours, binary, 24-hour format.
REQ-014 u  output  1  carry/borrow status returned to the update controller.
REQ-015 day_tick  output  1  one-cycle pulse when hours wrap in either direction.

Function
REQ-016 Field index K (2 bits) SHALL select: 0 = sec (limit 60), 1 = min (limit 60), 2 = hr (limit 24); K never takes value 3.
REQ-017 Kc SHALL set K <= 0 and u <= 0; Kc overrides Er and Lr's update of u in the same cycle.
REQ-018 Er with Kc low SHALL set K <= K+1 when K < 2; K SHALL hold at 2 otherwise.
REQ-019 La SHALL set A <= field[K], using K's value before the edge.
REQ-020 Ea SHALL compute A + operand(s) modulo limit[K]: A = limit-1 with +1 -> S = 0, c = 1; A = 0 with -1 -> S = limit-1, c = 1; otherwise c = 0.
REQ-021 Ea with s = 00 or 11 SHALL give S = A, c = 0.
REQ-022 Lr SHALL set field[K] <= S and u <= c; the other two fields SHALL be unchanged.
REQ-023 La, Ea, Lr, Er asserted together SHALL each use pre-edge register values, so A -> S -> field is a 3-cycle pipeline across consecutive controller states.
REQ-024 day_tick SHALL be high for exactly the cycle after an Lr with K = 2 and c = 1; otherwise low.
REQ-025 set_en SHALL load sec/min/hr from the set inputs, overriding any Lr write in the same cycle; K, A, S, c, u unchanged.
REQ-026 On set_en, any field value >= its limit SHALL be loaded as 0; in-range fields load normally.
REQ-027 Outputs sec/min/hr/u SHALL be direct register outputs with no combinational path from inputs.
REQ-028 When no control input is asserted, all registers SHALL hold.

Reset
REQ-029 rst_n low at a rising clk SHALL force sec = min = hr = 0, K = 0, A = S = 0, c = u = 0, day_tick = 0, overriding all other inputs.
REQ-030 Reset asserted mid-update SHALL abandon the update with no partial field write; the first post-reset cycle accepts controls normally.

Verification
REQ-031 Sequence Kc, La, s=01+Ea, Lr from 00:00:05 -> sec = 6, u = 0, min/hr unchanged.
REQ-032 From 00:00:59, Kc, La, Ea(+1), Lr, then Er, La, Ea, Lr -> 00:01:00, u = 1 after first Lr, u = 0 after second.
REQ-033 From 23:59:59, full three-field ripple -> 00:00:00, day_tick single pulse after hour Lr, u = 1.
REQ-034 From 00:00:00, Ea with s = 10 on sec -> sec = 59, u = 1; Er at K = 2 -> K stays 2.
REQ-035 set_en with set = 25:61:30 (hr:min:sec) while Lr is asserted -> hr = 0, min = 0, sec = 30; u and K unchanged.
REQ-036 rst_n low between Ea and Lr of an update from 12:34:56 -> all outputs 0, and no write of S appears after release.
